// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : input_pkg
//  Purpose  : Shared definitions for the button conditioner: repeat-FSM state
//             encoding, legal parameter ranges and elaboration-time helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package input_pkg;

    // Auto-repeat state per channel
    typedef enum logic [1:0] {
        ST_REL       = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_HOLD_RPT  = 2'd2
    } rpt_state_t;

    localparam int N_CH_MIN          = 1;
    localparam int N_CH_MAX          = 16;
    localparam int SYNC_STAGES_MIN   = 2;
    localparam int STABLE_CYCLES_MIN = 1;
    localparam int REPEAT_DELAY_MIN  = 1;
    localparam int REPEAT_PERIOD_MIN = 1;

    // Larger of two integers, used to size the shared hold counter
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // True when every parameter lies inside its legal range
    function automatic bit params_ok(
        input int n_ch,
        input int sync_stages,
        input int stable_cycles,
        input int repeat_delay,
        input int repeat_period
    );
        return (n_ch >= N_CH_MIN) && (n_ch <= N_CH_MAX) &&
               (sync_stages   >= SYNC_STAGES_MIN)   &&
               (stable_cycles >= STABLE_CYCLES_MIN) &&
               (repeat_delay  >= REPEAT_DELAY_MIN)  &&
               (repeat_period >= REPEAT_PERIOD_MIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module   : btn_channel
//  Purpose  : One button channel: input synchroniser, stability-count
//             debouncer with press/release pulses, and auto-repeat FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_channel
    import input_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [STAB_W-1:0] STAB_MAX    = STAB_W'(STABLE_CYCLES);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [STAB_W-1:0]      stab_cnt;
    logic                   differs;
    logic                   toggle;
    logic                   rise;
    logic                   fall;
    rpt_state_t             state;
    logic [HOLD_W-1:0]      hold_cnt;

    // Metastability chain: btn_in is used nowhere else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign synced  = sync_q[SYNC_STAGES-1];
    assign differs = synced ^ level;
    // Accept the new level only after STABLE_CYCLES differing samples plus this one
    assign toggle  = differs && (stab_cnt == STAB_MAX);
    assign rise    = toggle && !level;
    assign fall    = toggle && level;

    // Debouncer: count consecutive differing samples, any agreement restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt      <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= rise;
            release_pulse <= fall;
            if (toggle) begin
                level    <= ~level;
                stab_cnt <= '0;
            end else if (differs) begin
                stab_cnt <= stab_cnt + 1'b1;
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    // Auto-repeat FSM; a release overrides everything so repeat never follows it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_REL;
            hold_cnt     <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (fall) begin
                state    <= ST_REL;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_REL: begin
                        if (rise) begin
                            state    <= ST_HOLD_WAIT;
                            hold_cnt <= '0;
                        end
                    end
                    ST_HOLD_WAIT: begin
                        if (!repeat_en) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt == DELAY_LAST) begin
                            repeat_pulse <= 1'b1;
                            hold_cnt     <= '0;
                            state        <= ST_HOLD_RPT;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_HOLD_RPT: begin
                        if (!repeat_en) begin
                            state    <= ST_HOLD_WAIT;
                            hold_cnt <= '0;
                        end else if (hold_cnt == PERIOD_LAST) begin
                            repeat_pulse <= 1'b1;
                            hold_cnt     <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_REL;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : N_CH independent button conditioners (sync, debounce,
//             press/release pulses, auto-repeat). Wiring only.
//             release/repeat outputs carry a _pulse suffix because the bare
//             names are reserved words.
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
    import input_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    // Reject illegal parameter sets while elaborating
    if (!params_ok(N_CH, SYNC_STAGES, STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_param_error
        $error("button_conditioner: illegal parameter value");
    end

    // One conditioner per channel
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .btn_in        (btn_in[i]),
            .repeat_en     (repeat_en[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Self-checking bench for button_conditioner with a history-based
//             reference model (window rule for debounce, closed-form repeat
//             schedule measured from the press / last disable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int N_CH   = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int DELAY  = 8;
    localparam int PERIOD = 3;
    localparam int LAT    = SYNC + STABLE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_in = 2'b00;
    logic [1:0] repeat_en = 2'b00;
    logic [1:0] level, press, release_pulse, repeat_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [1:0] m_hb[$];
    logic [1:0] m_level, m_press, m_rel, m_rpt;
    int         m_anchor[2];
    int         m_edge;

    button_conditioner #(
        .N_CH          (N_CH),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .REPEAT_DELAY  (DELAY),
        .REPEAT_PERIOD (PERIOD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .repeat_en     (repeat_en),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_hb.delete();
        m_level = 2'b00;
        m_press = 2'b00;
        m_rel   = 2'b00;
        m_rpt   = 2'b00;
        m_anchor[0] = 0;
        m_anchor[1] = 0;
        m_edge  = 0;
    endtask

    // Level flips at edge e when the synchronised samples at edges e-STABLE..e
    // all disagree with the current level; sample at edge x is btn at edge x-SYNC.
    // Repeats fire DELAY + k*PERIOD edges after the press or the last disabled edge.
    task automatic model_step(input logic [1:0] b, input logic [1:0] en);
        int   e, idx, d;
        logic tog, s, prev;
        e = m_edge;
        m_hb.push_back(b);
        for (int ch = 0; ch < N_CH; ch++) begin
            prev = m_level[ch];
            tog  = 1'b1;
            for (int k = 0; k <= STABLE; k++) begin
                idx = e - k - SYNC;
                s   = (idx >= 0) ? m_hb[idx][ch] : 1'b0;
                if (s == prev) tog = 1'b0;
            end
            m_press[ch] = tog & ~prev;
            m_rel[ch]   = tog & prev;
            if (tog) m_level[ch] = ~prev;
            m_rpt[ch] = 1'b0;
            if (m_press[ch]) begin
                m_anchor[ch] = e;
            end else if (prev && m_level[ch]) begin
                if (!en[ch]) begin
                    m_anchor[ch] = e;
                end else begin
                    d = e - m_anchor[ch];
                    if (d >= DELAY && ((d - DELAY) % PERIOD) == 0) m_rpt[ch] = 1'b1;
                end
            end
        end
        m_edge = e + 1;
    endtask

    // Drive inputs, take one rising edge, advance the model, sample 1 ns later
    task automatic tick(input logic [1:0] b, input logic [1:0] en);
        btn_in    = b;
        repeat_en = en;
        @(posedge clk);
        model_step(b, en);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        btn_in    = 2'b00;
        repeat_en = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        btn_in    = 2'b11;
        repeat_en = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({level, press, release_pulse, repeat_pulse} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: got %b want 00000000", {level, press, release_pulse, repeat_pulse});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int t = 0; t < 10; t++) begin
            tick(2'b11, 2'b00);
            n_cmp++;
            if ({level, press, release_pulse, repeat_pulse} !== {m_level, m_press, m_rel, m_rpt}) begin
                n_bad++;
                $display("FAIL reset_hold_model edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", m_edge - 1,
                         level, press, release_pulse, repeat_pulse, m_level, m_press, m_rel, m_rpt);
            end
            if (t == LAT) begin
                n_cmp++;
                if (press !== 2'b11) begin
                    n_bad++;
                    $display("FAIL reset_hold_press edge %0d: got %b want 11", t, press);
                end
            end
        end
    endtask

    task automatic test_clean_step();
        do_reset();
        for (int t = 0; t < 12; t++) begin
            tick(2'b01, 2'b00);
            n_cmp++;
            if ({level, press, release_pulse, repeat_pulse} !== {m_level, m_press, m_rel, m_rpt}) begin
                n_bad++;
                $display("FAIL step_model edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", m_edge - 1,
                         level, press, release_pulse, repeat_pulse, m_level, m_press, m_rel, m_rpt);
            end
            if (t == LAT - 1 || t == LAT || t == LAT + 1) begin
                n_cmp++;
                if ({level[0], press[0], level[1], press[1]} !== {(t >= LAT) ? 1'b1 : 1'b0, (t == LAT) ? 1'b1 : 1'b0, 2'b00}) begin
                    n_bad++;
                    $display("FAIL step_edges edge %0d: got lvl0=%b prs0=%b lvl1=%b prs1=%b", t,
                             level[0], press[0], level[1], press[1]);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int np, nr;
        logic [1:0] b;
        np = 0;
        nr = 0;
        do_reset();
        for (int t = 0; t < 32; t++) begin
            b = (t < 12) ? (((t % 4) < 2) ? 2'b01 : 2'b00) : 2'b01;
            tick(b, 2'b00);
            np += int'(press[0]);
            nr += int'(release_pulse[0]);
            n_cmp++;
            if ({level, press, release_pulse, repeat_pulse} !== {m_level, m_press, m_rel, m_rpt}) begin
                n_bad++;
                $display("FAIL bounce_model edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", m_edge - 1,
                         level, press, release_pulse, repeat_pulse, m_level, m_press, m_rel, m_rpt);
            end
        end
        n_cmp++;
        if (np != 1 || nr != 0) begin
            n_bad++;
            $display("FAIL bounce_counts: got press=%0d release=%0d want press=1 release=0", np, nr);
        end
    endtask

    task automatic test_repeat();
        int rq[$];
        int exp_rpt[5] = '{14, 17, 20, 23, 26};
        int nr, rel_edge;
        nr = 0;
        rel_edge = -1;
        do_reset();
        for (int t = 0; t < 45; t++) begin
            tick((t < 23) ? 2'b01 : 2'b00, 2'b01);
            if (repeat_pulse[0]) rq.push_back(t);
            if (release_pulse[0]) begin
                nr++;
                rel_edge = t;
            end
            n_cmp++;
            if ({level, press, release_pulse, repeat_pulse} !== {m_level, m_press, m_rel, m_rpt}) begin
                n_bad++;
                $display("FAIL repeat_model edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", m_edge - 1,
                         level, press, release_pulse, repeat_pulse, m_level, m_press, m_rel, m_rpt);
            end
        end
        n_cmp++;
        if (rq.size() != 5) begin
            n_bad++;
            $display("FAIL repeat_count: got %0d pulses want 5", rq.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (rq[k] != exp_rpt[k]) begin
                    n_bad++;
                    $display("FAIL repeat_edge[%0d]: got %0d want %0d", k, rq[k], exp_rpt[k]);
                end
            end
        end
        n_cmp++;
        if (nr != 1 || rel_edge != 29) begin
            n_bad++;
            $display("FAIL repeat_release: got count=%0d edge=%0d want count=1 edge=29", nr, rel_edge);
        end
    endtask

    task automatic test_repeat_enable();
        int n_early, first;
        n_early = 0;
        first   = -1;
        do_reset();
        for (int t = 0; t < 45; t++) begin
            tick(2'b01, (t >= 31) ? 2'b01 : 2'b00);
            if (repeat_pulse[0] && t <= 30) n_early++;
            if (repeat_pulse[0] && first < 0) first = t;
            n_cmp++;
            if ({level, press, release_pulse, repeat_pulse} !== {m_level, m_press, m_rel, m_rpt}) begin
                n_bad++;
                $display("FAIL rpt_en_model edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", m_edge - 1,
                         level, press, release_pulse, repeat_pulse, m_level, m_press, m_rel, m_rpt);
            end
        end
        n_cmp++;
        if (n_early != 0 || first != 38) begin
            n_bad++;
            $display("FAIL rpt_en_first: got early=%0d first=%0d want early=0 first=38", n_early, first);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int t = 0; t <= LAT; t++) tick(2'b01, 2'b01);
        n_cmp++;
        if ({level[0], press[0]} !== 2'b11) begin
            n_bad++;
            $display("FAIL midrst_pre: got lvl/prs %b want 11", {level[0], press[0]});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({level, press, release_pulse, repeat_pulse} !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_clear: got %b want 00000000", {level, press, release_pulse, repeat_pulse});
        end
        #1;
        rst = 1'b0;
        model_reset();
        for (int t = 0; t < 10; t++) begin
            tick(2'b01, 2'b01);
            n_cmp++;
            if ({level, press, release_pulse, repeat_pulse} !== {m_level, m_press, m_rel, m_rpt}) begin
                n_bad++;
                $display("FAIL midrst_model edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", m_edge - 1,
                         level, press, release_pulse, repeat_pulse, m_level, m_press, m_rel, m_rpt);
            end
            if (t == LAT) begin
                n_cmp++;
                if (press[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL midrst_repress: got %b want 1", press[0]);
                end
            end
        end
    endtask

    task automatic test_both();
        do_reset();
        for (int t = 0; t < 10; t++) begin
            tick(2'b11, 2'b00);
            n_cmp++;
            if ({level, press, release_pulse, repeat_pulse} !== {m_level, m_press, m_rel, m_rpt}) begin
                n_bad++;
                $display("FAIL both_model edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", m_edge - 1,
                         level, press, release_pulse, repeat_pulse, m_level, m_press, m_rel, m_rpt);
            end
            if (t == LAT) begin
                n_cmp++;
                if (press !== 2'b11) begin
                    n_bad++;
                    $display("FAIL both_press: got %b want 11", press);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] b, en;
        int run[2];
        b = 2'b00;
        en = 2'b11;
        run[0] = 0;
        run[1] = 0;
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (run[ch] == 0) begin
                    b[ch]   = ~b[ch];
                    run[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 7));
                end
                run[ch]--;
            end
            if ($urandom_range(0, 24) == 0) en = 2'($urandom_range(0, 3));
            tick(b, en);
            n_cmp++;
            if ({level, press, release_pulse, repeat_pulse} !== {m_level, m_press, m_rel, m_rpt}) begin
                n_bad++;
                $display("FAIL random_model edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", m_edge - 1,
                         level, press, release_pulse, repeat_pulse, m_level, m_press, m_rel, m_rpt);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_step();
        test_bounce();
        test_repeat();
        test_repeat_enable();
        test_reset_mid();
        test_both();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
